// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: captures one cipher key and streams round keys 0..10
// over a valid/ready handshake, keeping only the current round key.
package aes_model_pack;
   // table[row][col]; FIPS-197 byte k sits at [k%4][k/4]
   typedef logic [3:0][3:0][7:0] byte_table;
endpackage

module aes_key_schedule #(
   parameter int NUM_ROUNDS = 10,
   parameter int IDX_W      = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  aes_model_pack::byte_table key_in,
   input  logic                      key_valid,
   output logic                      key_ready,
   output aes_model_pack::byte_table rk_out,
   output logic                      rk_valid,
   input  logic                      rk_ready,
   output logic [IDX_W-1:0]          rk_index,
   output logic                      rk_last,
   output logic                      busy
);
   if (NUM_ROUNDS != 10) begin : g_bad_rounds
      $error("aes_key_schedule supports only NUM_ROUNDS = 10");
   end
   if (IDX_W < 4) begin : g_bad_idx_w
      $error("aes_key_schedule needs IDX_W >= 4");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t                    state_q, state_d;
   aes_model_pack::byte_table rk_q, rk_d, next_key_s;
   logic [IDX_W-1:0]          rk_index_q, rk_index_d;
   logic                      key_ready_q, key_ready_d;
   logic                      rk_valid_q, rk_valid_d;
   logic                      busy_q, busy_d;
   logic [7:0]                rcon_s;
   logic [3:0][7:0]           t_s, c0_s, c1_s, c2_s, c3_s;

   // round constant for the key about to be produced (rcon[rk_index+1])
   always_comb begin
      rcon_s = 8'h00;
      case (rk_index_q)
         IDX_W'(0): rcon_s = 8'h01;
         IDX_W'(1): rcon_s = 8'h02;
         IDX_W'(2): rcon_s = 8'h04;
         IDX_W'(3): rcon_s = 8'h08;
         IDX_W'(4): rcon_s = 8'h10;
         IDX_W'(5): rcon_s = 8'h20;
         IDX_W'(6): rcon_s = 8'h40;
         IDX_W'(7): rcon_s = 8'h80;
         IDX_W'(8): rcon_s = 8'h1b;
         IDX_W'(9): rcon_s = 8'h36;
         default:   rcon_s = 8'h00;
      endcase
   end

   // one FIPS-197 expansion step; RotWord folds into the row offset on column 3
   always_comb begin
      t_s        = '0;
      c0_s       = '0;
      c1_s       = '0;
      c2_s       = '0;
      c3_s       = '0;
      next_key_s = '0;
      for (int r = 0; r < 4; r++) begin
         t_s[r] = sbox(rk_q[(r + 1) % 4][3]) ^ ((r == 0) ? rcon_s : 8'h00);
      end
      for (int r = 0; r < 4; r++) begin
         c0_s[r] = rk_q[r][0] ^ t_s[r];
         c1_s[r] = rk_q[r][1] ^ c0_s[r];
         c2_s[r] = rk_q[r][2] ^ c1_s[r];
         c3_s[r] = rk_q[r][3] ^ c2_s[r];
         next_key_s[r] = {c3_s[r], c2_s[r], c1_s[r], c0_s[r]};
      end
   end

   // next-state and registered-output decode
   always_comb begin
      state_d    = state_q;
      rk_d       = rk_q;
      rk_index_d = rk_index_q;
      case (state_q)
         IDLE: begin
            if (key_valid) begin
               rk_d       = key_in;
               rk_index_d = '0;
               state_d    = STREAM;
            end else begin
               state_d    = IDLE;
            end
         end
         STREAM: begin
            if (rk_ready && (rk_index_q == LAST_IDX)) begin
               rk_index_d = '0;
               state_d    = IDLE;
            end else if (rk_ready) begin
               rk_d       = next_key_s;
               rk_index_d = rk_index_q + IDX_W'(1);
            end else begin
               state_d    = STREAM;
            end
         end
         default: begin
            state_d    = IDLE;
            rk_index_d = '0;
         end
      endcase
      key_ready_d = (state_d == IDLE);
      rk_valid_d  = (state_d == STREAM);
      busy_d      = (state_d == STREAM);
   end

   // state and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rk_q        <= '0;
         rk_index_q  <= '0;
         key_ready_q <= 1'b1;
         rk_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rk_q        <= rk_d;
         rk_index_q  <= rk_index_d;
         key_ready_q <= key_ready_d;
         rk_valid_q  <= rk_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign key_ready = key_ready_q;
   assign rk_out    = rk_q;
   assign rk_valid  = rk_valid_q;
   assign rk_index  = rk_index_q;
   assign busy      = busy_q;
   assign rk_last   = (rk_index_q == LAST_IDX) & rk_valid_q;

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative AES-128 key expansion engine.
- Sits directly upstream of the round datapath and drives its round_key input. Its rk_last output drives the datapath's last_round select.
- Accepts one 128-bit cipher key, then streams round keys 0..10 one at a time over a valid/ready handshake.
- Generates one new key per accepted transfer. Only the current round key is stored, no full key table.

Parameters:
NUM_ROUNDS, 10, number of rounds; only 10 (AES-128) is supported, and any other value is a compile-time error.
IDX_W, 4, width of rk_index; must hold NUM_ROUNDS.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
key_in  input  aes_model_pack::byte_table (128)  cipher key; FIPS-197 byte k maps to table[k%4][k/4] (row, column)
key_valid  input  1  key_in valid
key_ready  output  1  engine idle and able to accept a key
rk_out  output  aes_model_pack::byte_table (128)  current round key, same byte mapping as key_in
rk_valid  output  1  rk_out/rk_index/rk_last valid
rk_ready  input  1  consumer accepts rk_out
rk_index  output  IDX_W  round number of rk_out, 0..10
rk_last  output  1  high when rk_index == NUM_ROUNDS; feeds last_round
busy  output  1  high in STREAM state

Behaviour:
- Reset: synchronous, active-low. While rst_n = 0 at a clock edge, the next state is:
  - state IDLE, key_ready=1, rk_valid=0, rk_index=0, rk_last=0, busy=0, rk_out=0.
- Reset mid-stream aborts immediately. No further rk_valid until a new key is accepted.
- States: IDLE and STREAM.
- IDLE:
  - key_ready=1, rk_valid=0.
  - A key handshake is key_valid & key_ready on a clock edge.
  - On key handshake: rk_out <= key_in, rk_index <= 0, go to STREAM.
  - rk_valid=1 in the following cycle (1-cycle latency, round key 0 = cipher key).
- STREAM:
  - key_ready=0; key_valid is ignored and no key is captured.
  - rk_valid=1 continuously, and rk_out/rk_index held stable while rk_ready=0 (AXI-style: no retraction, no change under backpressure).
  - On transfer (rk_valid & rk_ready) with rk_index < 10: rk_out <= next(rk_out, rcon[rk_index+1]), rk_index <= rk_index+1. The new key is valid the very next cycle, so back-to-back transfers run at 1 key/clk.
  - On transfer with rk_index == 10: go to IDLE, rk_valid <= 0, rk_index <= 0, key_ready=1 next cycle.
  - A new key can therefore be accepted no earlier than 1 cycle after the last transfer. Full 11-key stream with rk_ready tied high: 12 cycles from key handshake to key_ready.
- rk_last = (rk_index == 10) & rk_valid; combinational from registers.
- next(), per FIPS-197. Current words w0..w3 are the columns; the new words are:
  - t = SubWord(RotWord(w3)) ^ {rcon,00,00,00}
  - w0' = w0^t
  - w1' = w1^w0'
  - w2' = w2^w1'
  - w3' = w3^w2'
- RotWord: [a0,a1,a2,a3] -> [a1,a2,a3,a0] (row index = byte within word).
- SubWord: 4 combinational FIPS-197 S-box lookups. This is the only combinational path into the rk_out register; there is no output-to-output combinational path.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36; index 0 is unused. Implemented as a case on rk_index, not an xtime chain.
- Byte arithmetic is pure XOR with no carries. rk_index never exceeds 10, so there is no wrap.
- Simultaneous events:
  - key_valid during STREAM has no effect; the upstream source must hold the key until key_ready.
  - rst_n low overrides every handshake in the same cycle.

Test Plan:
- FIPS-197 App. A:
  - Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1.
  - Required: rk0 = key; rk1 = a0fafe1788542cb123a339392a6c7605; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1.
  - Required: 11 transfers in 11 consecutive cycles, key_ready high in cycle 12.
- All-zero key:
  - Required: rk1 = 62636363626363636263636362636363 and rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure, App. A key:
  - rk_ready is random at 30%.
  - Required: identical key sequence to the first scenario.
  - Required: rk_out/rk_index stable whenever rk_valid & !rk_ready, and rk_valid never drops before index 10 is transferred.
- Key during stream:
  - Pulse key_valid with key ffff…ff at index 4.
  - Required: stream continues with the App. A sequence, key_ready stays 0, and the new key is accepted only after rk10.
- Reset mid-stream:
  - Deassert rst_n for one cycle at index 6.
  - Required: next cycle rk_valid=0, key_ready=1, rk_index=0.
  - Required: a following zero-key load yields the correct rk0..rk10.
- Back-to-back keys:
  - key_valid held high with two keys.
  - Required: the second key is accepted the cycle key_ready rises, with exactly one idle cycle (rk_valid=0) between the two streams.
